// File: rtl/vend_dispense_engine.sv
// Dispense and change engine: checks stock and funds, hands one item to the item hopper,
// then pays change (or a full refund) as greedy-denomination coins over a valid/ready handshake.
module vend_dispense_engine #(
  parameter int CURRENCY_WIDTH  = 7,
  parameter int ITEM_ADDR_WIDTH = 10,
  parameter int PRICE_WIDTH     = 16,
  parameter int COUNT_WIDTH     = 8,
  parameter int DENOM_3         = 50,
  parameter int DENOM_2         = 10,
  parameter int DENOM_1         = 5,
  parameter int DENOM_0         = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vend_req,
  input  logic                       cancel_req,
  input  logic [ITEM_ADDR_WIDTH-1:0] item_selected,
  input  logic [CURRENCY_WIDTH-1:0]  total_currency,
  input  logic [PRICE_WIDTH-1:0]     item_price,
  input  logic [COUNT_WIDTH-1:0]     avail_count,
  input  logic                       dispense_ready,
  input  logic                       coin_ready,
  output logic                       busy,
  output logic                       dispense_valid,
  output logic [ITEM_ADDR_WIDTH-1:0] item_dispensed,
  output logic                       stock_dec,
  output logic                       coin_valid,
  output logic [1:0]                 coin_sel,
  output logic [CURRENCY_WIDTH-1:0]  change_remaining,
  output logic                       done,
  output logic [1:0]                 status
);

  localparam int CMP_WIDTH = (PRICE_WIDTH > CURRENCY_WIDTH) ? PRICE_WIDTH : CURRENCY_WIDTH;

  localparam logic [CURRENCY_WIDTH-1:0] D3 = CURRENCY_WIDTH'(DENOM_3);
  localparam logic [CURRENCY_WIDTH-1:0] D2 = CURRENCY_WIDTH'(DENOM_2);
  localparam logic [CURRENCY_WIDTH-1:0] D1 = CURRENCY_WIDTH'(DENOM_1);
  localparam logic [CURRENCY_WIDTH-1:0] D0 = CURRENCY_WIDTH'(DENOM_0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DISPENSE,
    S_CHANGE,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_OK          = 2'd0,
    ST_NO_STOCK    = 2'd1,
    ST_SHORT_FUNDS = 2'd2,
    ST_REFUND      = 2'd3
  } status_t;

  // Largest coin not exceeding the amount still owed.
  function automatic logic [1:0] pick_denom(input logic [CURRENCY_WIDTH-1:0] v);
    if (v >= D3)      return 2'd3;
    else if (v >= D2) return 2'd2;
    else if (v >= D1) return 2'd1;
    else              return 2'd0;
  endfunction

  function automatic logic [CURRENCY_WIDTH-1:0] denom_value(input logic [1:0] sel);
    case (sel)
      2'd3:    return D3;
      2'd2:    return D2;
      2'd1:    return D1;
      default: return D0;
    endcase
  endfunction

  state_t                       state, state_n;
  status_t                      result_q, result_n;
  logic [ITEM_ADDR_WIDTH-1:0]   item_q, item_n;
  logic [CURRENCY_WIDTH-1:0]    total_q, total_n;
  logic [CURRENCY_WIDTH-1:0]    change_n;
  logic                         busy_n, dispense_valid_n, coin_valid_n, done_n;
  logic [ITEM_ADDR_WIDTH-1:0]   item_dispensed_n;
  logic [1:0]                   coin_sel_n, status_n;
  logic [CMP_WIDTH-1:0]         price_ext, total_ext;

  assign price_ext = CMP_WIDTH'(item_price);
  assign total_ext = CMP_WIDTH'(total_q);

  // The stock pulse must coincide with the item handshake itself, so it is the one
  // output formed from a ready input; it is gated by the registered dispense_valid.
  assign stock_dec = dispense_valid & dispense_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    state_n  = state;
    result_n = result_q;
    item_n   = item_q;
    total_n  = total_q;
    change_n = change_remaining;

    case (state)
      S_IDLE: begin
        if (cancel_req) begin
          change_n = total_currency;
          result_n = ST_REFUND;
          state_n  = S_CHANGE;
        end else if (vend_req) begin
          item_n  = item_selected;
          total_n = total_currency;
          state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (avail_count == '0) begin
          result_n = ST_NO_STOCK;
          change_n = total_q;
          state_n  = S_CHANGE;
        end else if (price_ext > total_ext) begin
          result_n = ST_SHORT_FUNDS;
          change_n = total_q;
          state_n  = S_CHANGE;
        end else begin
          result_n = ST_OK;
          change_n = CURRENCY_WIDTH'(total_ext - price_ext);
          state_n  = S_DISPENSE;
        end
      end
      S_DISPENSE: begin
        if (dispense_ready) state_n = S_CHANGE;
      end
      S_CHANGE: begin
        if (change_remaining == '0)
          state_n = S_DONE;
        else if (coin_valid && coin_ready)
          change_n = change_remaining - denom_value(coin_sel);
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Outputs are computed for the upcoming state and registered, so a stalled
    // coin keeps its selection because change_n is unchanged until the handshake.
    busy_n           = (state_n != S_IDLE);
    dispense_valid_n = (state_n == S_DISPENSE);
    item_dispensed_n = dispense_valid_n ? item_n : '0;
    coin_valid_n     = (state_n == S_CHANGE) && (change_n != '0);
    coin_sel_n       = coin_valid_n ? pick_denom(change_n) : 2'd0;
    done_n           = (state_n == S_DONE);
    status_n         = done_n ? result_n : status;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      result_q         <= ST_OK;
      item_q           <= '0;
      total_q          <= '0;
      change_remaining <= '0;
      busy             <= 1'b0;
      dispense_valid   <= 1'b0;
      item_dispensed   <= '0;
      coin_valid       <= 1'b0;
      coin_sel         <= 2'd0;
      done             <= 1'b0;
      status           <= 2'd0;
    end else begin
      state            <= state_n;
      result_q         <= result_n;
      item_q           <= item_n;
      total_q          <= total_n;
      change_remaining <= change_n;
      busy             <= busy_n;
      dispense_valid   <= dispense_valid_n;
      item_dispensed   <= item_dispensed_n;
      coin_valid       <= coin_valid_n;
      coin_sel         <= coin_sel_n;
      done             <= done_n;
      status           <= status_n;
    end
  end

endmodule

// File: tb/tb_vend_dispense_engine.sv
// Self-checking bench: a transaction-level model (status, item, greedy coin list) is
// compared against the hopper handshakes every cycle, plus directed timing/literal checks.
module tb_vend_dispense_engine;

  localparam int CW = 7;
  localparam int IW = 10;
  localparam int PW = 16;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          vend_req, cancel_req;
  logic [IW-1:0] item_selected;
  logic [CW-1:0] total_currency;
  logic [PW-1:0] item_price;
  logic [NW-1:0] avail_count;
  logic          dispense_ready, coin_ready;
  logic          busy, dispense_valid, stock_dec, coin_valid, done;
  logic [IW-1:0] item_dispensed;
  logic [1:0]    coin_sel, status;
  logic [CW-1:0] change_remaining;

  vend_dispense_engine dut (
    .clk              (clk),
    .rst              (rst),
    .vend_req         (vend_req),
    .cancel_req       (cancel_req),
    .item_selected    (item_selected),
    .total_currency   (total_currency),
    .item_price       (item_price),
    .avail_count      (avail_count),
    .dispense_ready   (dispense_ready),
    .coin_ready       (coin_ready),
    .busy             (busy),
    .dispense_valid   (dispense_valid),
    .item_dispensed   (item_dispensed),
    .stock_dec        (stock_dec),
    .coin_valid       (coin_valid),
    .coin_sel         (coin_sel),
    .change_remaining (change_remaining),
    .done             (done),
    .status           (status)
  );

  always #5 clk = ~clk;

  int checks, failures, cyc;
  int rand_ready, hold_disp, coin_toggle;
  // Model of the current transaction
  int exp_status, exp_disp, exp_item, exp_change, exp_n;
  int exp_coins [16];
  // Observations of the current transaction
  int coin_idx, paid_sum, disp_count, obs_code;
  int done_count, done_cyc, dv_rise_cyc, cv_rise_cyc, last_status, req_cyc;
  int prev_dv, prev_dr, prev_cv, prev_cr, prev_sel;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int denom_of(input int sel);
    case (sel)
      3:       return 50;
      2:       return 10;
      1:       return 5;
      default: return 1;
    endcase
  endfunction

  // Outcome of a request from the business rules, with the greedy coin breakdown.
  task automatic plan(input int cancel, input int item, input int total,
                      input int price, input int stock);
    int amt;
    int s;
    exp_disp = 0;
    if (cancel != 0) begin
      exp_status = 3; amt = total;
    end else if (stock == 0) begin
      exp_status = 1; amt = total;
    end else if (price > total) begin
      exp_status = 2; amt = total;
    end else begin
      exp_status = 0; exp_disp = 1; amt = total - price;
    end
    exp_item   = item;
    exp_change = amt;
    exp_n      = 0;
    while (amt > 0) begin
      s = (amt >= 50) ? 3 : (amt >= 10) ? 2 : (amt >= 5) ? 1 : 0;
      exp_coins[exp_n] = s;
      exp_n++;
      amt -= denom_of(s);
    end
    coin_idx   = 0;
    paid_sum   = 0;
    disp_count = 0;
    obs_code   = 1;
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_dv = 0; prev_dr = 0; prev_cv = 0; prev_cr = 0; prev_sel = 0;
        last_status = 0;
      end else begin
        if (dispense_valid) begin
          check("dispense_allowed", exp_disp, 1);
          check("item_dispensed", int'(item_dispensed), exp_item);
          check("change_during_dispense", int'(change_remaining), exp_change);
          check("stock_dec_handshake", int'(stock_dec), int'(dispense_ready));
          if (dispense_ready) disp_count++;
          if (prev_dv == 0) dv_rise_cyc = cyc;
        end else begin
          check("item_idle_zero", int'(item_dispensed), 0);
          check("stock_dec_idle", int'(stock_dec), 0);
          if (prev_dv != 0 && prev_dr == 0) check("dispense_dropped_stall", 0, 1);
        end

        if (coin_valid) begin
          if (coin_idx < exp_n) check("coin_sel", int'(coin_sel), exp_coins[coin_idx]);
          else check("extra_coin", coin_idx, exp_n);
          check("change_remaining", int'(change_remaining), exp_change - paid_sum);
          if (prev_cv != 0 && prev_cr == 0) check("coin_sel_stall", int'(coin_sel), prev_sel);
          if (coin_ready) begin
            obs_code = obs_code * 10 + int'(coin_sel);
            paid_sum += denom_of(int'(coin_sel));
            coin_idx++;
          end
          if (prev_cv == 0) cv_rise_cyc = cyc;
        end else begin
          check("coin_sel_idle", int'(coin_sel), 0);
          if (prev_cv != 0 && prev_cr == 0) check("coin_dropped_stall", 0, 1);
        end

        if (dispense_valid || coin_valid || done) check("busy_active", int'(busy), 1);

        if (done) begin
          check("done_status", int'(status), exp_status);
          check("done_coin_count", coin_idx, exp_n);
          check("done_dispense_count", disp_count, exp_disp);
          check("done_change_zero", int'(change_remaining), 0);
          last_status = int'(status);
          done_count++;
          done_cyc = cyc;
        end else begin
          check("status_hold", int'(status), last_status);
        end

        prev_dv  = int'(dispense_valid);
        prev_dr  = int'(dispense_ready);
        prev_cv  = int'(coin_valid);
        prev_cr  = int'(coin_ready);
        prev_sel = int'(coin_sel);
      end
    end
  endtask

  // Drives both ready inputs just after each rising edge.
  task automatic ready_loop();
    int stall;
    stall = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (dispense_valid && hold_disp != 0 && stall < 3) begin
        dispense_ready = 1'b0;
        stall++;
      end else begin
        dispense_ready = (rand_ready != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!dispense_valid) stall = 0;
      end
      if (coin_toggle != 0)     coin_ready = ~coin_ready;
      else if (rand_ready != 0) coin_ready = ($urandom_range(0, 2) != 0);
      else                      coin_ready = 1'b1;
    end
  endtask

  task automatic run_txn(input int cancel, input int vend, input int item, input int total,
                         input int price, input int stock, input int stray);
    int start;
    int n;
    plan(cancel, item, total, price, stock);
    start = done_count;
    @(posedge clk); #1;
    item_selected  = IW'(item);
    total_currency = CW'(total);
    item_price     = PW'(price);
    avail_count    = NW'(stock);
    vend_req       = (vend != 0);
    cancel_req     = (cancel != 0);
    @(posedge clk); #1;
    req_cyc    = cyc;
    vend_req   = 1'b0;
    cancel_req = (stray != 0);   // arrives while busy, must be ignored
    @(posedge clk); #1;
    cancel_req = 1'b0;
    n = 0;
    while (done_count == start && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    check("done_within_budget", done_count - start, 1);
    @(negedge clk); #1;
    check("idle_after_done", int'(busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_dispense_valid"}, int'(dispense_valid), 0);
    check({tag, "_item_dispensed"}, int'(item_dispensed), 0);
    check({tag, "_stock_dec"}, int'(stock_dec), 0);
    check({tag, "_coin_valid"}, int'(coin_valid), 0);
    check({tag, "_coin_sel"}, int'(coin_sel), 0);
    check({tag, "_change_remaining"}, int'(change_remaining), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_status"}, int'(status), 0);
  endtask

  initial begin
    int start;
    int c, v, total, price, stock, item, stray;
    checks = 0; failures = 0; cyc = 0; done_count = 0; last_status = 0;
    rand_ready = 0; hold_disp = 0; coin_toggle = 0;
    vend_req = 1'b0; cancel_req = 1'b0;
    item_selected = '0; total_currency = '0; item_price = '0; avail_count = '0;
    dispense_ready = 1'b1; coin_ready = 1'b1;
    plan(0, 0, 0, 0, 1);
    exp_disp = 0;
    fork
      monitor_loop();
      ready_loop();
    join_none

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    @(posedge clk); #2 rst = 1'b0;

    // Normal vend with change 78 = 50+10+10+5+1+1+1
    run_txn(0, 1, 5, 100, 22, 3, 0);
    check("vend_coin_sequence", obs_code, 13221000);
    check("vend_status", int'(status), 0);
    check("vend_dispense_at_req_plus1", dv_rise_cyc - req_cyc, 1);
    check("vend_first_coin_at_req_plus2", cv_rise_cyc - req_cyc, 2);

    // Exact payment: no coins, done three cycles after the request is sampled
    run_txn(0, 1, 9, 30, 30, 1, 0);
    check("exact_no_coins", obs_code, 1);
    check("exact_done_timing", done_cyc - req_cyc, 3);
    check("exact_status", int'(status), 0);

    // Out of stock: full refund of 40
    run_txn(0, 1, 17, 40, 10, 0, 0);
    check("nostock_coins", obs_code, 12222);
    check("nostock_status", int'(status), 1);

    // Price wider than the currency field: short funds, refund 127
    run_txn(0, 1, 3, 127, 300, 5, 0);
    check("short_coins", obs_code, 13322100);
    check("short_status", int'(status), 2);

    // Backpressure on both hoppers
    hold_disp = 1; coin_toggle = 1;
    run_txn(0, 1, 700, 100, 22, 2, 0);
    check("stall_coin_sequence", obs_code, 13221000);
    check("stall_status", int'(status), 0);
    hold_disp = 0; coin_toggle = 0;

    // Cancel and vend together: cancel wins
    run_txn(1, 1, 44, 15, 5, 4, 0);
    check("cancel_coins", obs_code, 121);
    check("cancel_status", int'(status), 3);
    check("cancel_coin_at_req", cv_rise_cyc - req_cyc, 0);

    // Reset in the middle of paying a refund
    plan(1, 0, 127, 0, 1);
    start = done_count;
    @(posedge clk); #1;
    total_currency = CW'(127); cancel_req = 1'b1;
    @(posedge clk); #1 cancel_req = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_coin_active", int'(coin_valid), 1);
    rst = 1'b1;
    #1 check_all_zero("midreset");
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("no_done_after_reset", done_count, start);
    check("idle_after_reset", int'(busy), 0);

    // Randomized transactions with random readies
    rand_ready = 1;
    for (int t = 0; t < 40; t++) begin
      c     = ($urandom_range(0, 5) == 0) ? 1 : 0;
      v     = (c != 0) ? int'($urandom_range(0, 1)) : 1;
      total = int'($urandom_range(0, 127));
      price = ($urandom_range(0, 7) == 0) ? int'($urandom_range(128, 65535))
                                          : int'($urandom_range(0, 135));
      stock = int'($urandom_range(0, 3));
      item  = int'($urandom_range(0, 1023));
      stray = ($urandom_range(0, 3) == 0) ? 1 : 0;
      run_txn(c, v, item, total, price, stock, stray);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    rand_ready = 0;

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
